tim_psc_shadow: RTL and testbench

Parametrised timer prescaler with a preload (shadow) register and an active register. Divides the timer clock by PSC+1 and emits a one-cycle count-enable tick that drives the timer counter. A new PSC value is written to the preload register and only takes effect on an update event: counter overflow from the counter block, or the software UG bit. This keeps the division ratio glitch-free mid-period.

---
 rtl/tim_psc_shadow.sv | 63 ++++++
 tb/tb_tim_psc_shadow.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tim_psc_shadow.sv
// tim_psc_shadow: timer prescaler with preload/active PSC registers and count-enable tick.
// Optional TIM_PSC_PRELOAD_BYPASS_EN adds psc_pe; psc_pe=0 makes PSC writes take effect immediately.
module tim_psc_shadow #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_psc,
  input  logic [WIDTH-1:0] i_psc,
  input  logic             ug,
  input  logic             uev_in,
`ifdef TIM_PSC_PRELOAD_BYPASS_EN
  input  logic             psc_pe,
`endif
  output logic [WIDTH-1:0] o_psc_pre,
  output logic [WIDTH-1:0] o_psc_act,
  output logic [WIDTH-1:0] o_psc_cnt,
  output logic             o_tick,
  output logic             o_pend
);
  logic [WIDTH-1:0] r_pre, r_act, r_cnt;
  logic             r_tick, r_pend;
  logic             w_xfer, w_bypass, w_wrap;
  assign w_xfer = ug | uev_in;
`ifdef TIM_PSC_PRELOAD_BYPASS_EN
  assign w_bypass = wr_psc & ~psc_pe;
`else
  assign w_bypass = 1'b0;
`endif
  // >= rather than == so a shrunk PSC below the current count wraps at once
  assign w_wrap = r_cnt >= r_act;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre  <= '0;
      r_act  <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      if (wr_psc) r_pre <= i_psc;
      if (w_bypass) r_act <= i_psc;
      else if (w_xfer) r_act <= r_pre;
      if (w_bypass) r_pend <= 1'b0;
      else if (wr_psc) r_pend <= 1'b1;
      else if (w_xfer) r_pend <= 1'b0;
      if (ug) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (en) begin
        r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
        r_tick <= w_wrap;
      end else begin
        r_tick <= 1'b0;
      end
    end
  end
  assign o_psc_pre = r_pre;
  assign o_psc_act = r_act;
  assign o_psc_cnt = r_cnt;
  assign o_tick    = r_tick;
  assign o_pend    = r_pend;
endmodule

// File: tb/tb_tim_psc_shadow.sv
// tb_tim_psc_shadow: directed and random checks of tim_psc_shadow against a behavioural model.
module tb_tim_psc_shadow;
  localparam int W = 4;
  localparam int M = (1 << W) - 1;
  logic clk = 0, rst = 1, en = 0, wr_psc = 0, ug = 0, uev_in = 0;
  logic [W-1:0] i_psc = '0;
`ifdef TIM_PSC_PRELOAD_BYPASS_EN
  logic psc_pe = 1;
`endif
  logic [W-1:0] o_psc_pre, o_psc_act, o_psc_cnt;
  logic o_tick, o_pend;
  int m_pre = 0, m_act = 0, m_cnt = 0, m_tick = 0, m_pend = 0;
  int total = 0, passed = 0;

  tim_psc_shadow #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_psc(wr_psc), .i_psc(i_psc), .ug(ug), .uev_in(uev_in),
`ifdef TIM_PSC_PRELOAD_BYPASS_EN
    .psc_pe(psc_pe),
`endif
    .o_psc_pre(o_psc_pre), .o_psc_act(o_psc_act), .o_psc_cnt(o_psc_cnt),
    .o_tick(o_tick), .o_pend(o_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pre"}, int'(o_psc_pre), m_pre);
    chk({tag, ".act"}, int'(o_psc_act), m_act);
    chk({tag, ".cnt"}, int'(o_psc_cnt), m_cnt);
    chk({tag, ".tick"}, int'(o_tick), m_tick);
    chk({tag, ".pend"}, int'(o_pend), m_pend);
  endtask

  task automatic model_reset();
    m_pre = 0; m_act = 0; m_cnt = 0; m_tick = 0; m_pend = 0;
  endtask

  // One clock: drive inputs, advance the model by the prescaler rules, compare all outputs.
  task automatic cyc(input string tag, input bit e, input bit w, input int p, input bit u, input bit v);
    int old_act;
    bit byp;
    en = e; wr_psc = w; i_psc = p[W-1:0]; ug = u; uev_in = v;
    @(posedge clk);
    byp = 0;
`ifdef TIM_PSC_PRELOAD_BYPASS_EN
    byp = w && !psc_pe;
`endif
    old_act = m_act;
    if (u) begin
      m_cnt = 0; m_tick = 0;
    end else if (e) begin
      m_tick = (m_cnt >= old_act) ? 1 : 0;
      m_cnt = m_tick ? 0 : m_cnt + 1;
    end else m_tick = 0;
    if (byp) begin
      m_act = p & M; m_pre = p & M; m_pend = 0;
    end else begin
      if (u || v) begin m_act = m_pre; m_pend = 0; end
      if (w) begin m_pre = p & M; m_pend = 1; end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    int ticks;
    int seq[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    #12;
    check_all("reset");
    @(negedge clk) rst = 0;
    // PSC=0: tick every cycle
    for (int i = 0; i < 4; i++) begin
      cyc("psc0", 1, 0, 0, 0, 0);
      chk("psc0_tick", int'(o_tick), 1);
      chk("psc0_cnt", int'(o_psc_cnt), 0);
    end
    // asynchronous reset mid-run
    #2 rst = 1;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk) rst = 0;
    // PSC=3 via ug
    cyc("wr3", 0, 1, 3, 0, 0);
    chk("wr3_pend", int'(o_pend), 1);
    cyc("ug3", 1, 0, 0, 1, 0);
    chk("ug3_act", int'(o_psc_act), 3);
    chk("ug3_pend", int'(o_pend), 0);
    for (int i = 0; i < 8; i++) begin
      cyc("div4", 1, 0, 0, 0, 0);
      chk("div4_cnt", int'(o_psc_cnt), seq[i]);
      chk("div4_tick", int'(o_tick), seq[i] == 0 ? 1 : 0);
    end
    // buffered write of 7, applied on uev_in
    cyc("wr7", 1, 1, 7, 0, 0);
    chk("wr7_act", int'(o_psc_act), 3);
    for (int i = 0; i < 5; i++) cyc("hold4", 1, 0, 0, 0, 0);
    cyc("uev7", 1, 0, 0, 0, 1);
    chk("uev7_act", int'(o_psc_act), 7);
    for (int i = 0; i < 18; i++) cyc("div8", 1, 0, 0, 0, 0);
    // shrink below current count: immediate wrap
    cyc("wr9", 0, 1, 9, 0, 0);
    cyc("ug9", 1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc("to6", 1, 0, 0, 0, 0);
    chk("at6_cnt", int'(o_psc_cnt), 6);
    cyc("wr2", 0, 1, 2, 0, 0);
    cyc("uev2", 0, 0, 0, 0, 1);
    chk("uev2_act", int'(o_psc_act), 2);
    cyc("wrap", 1, 0, 0, 0, 0);
    chk("wrap_cnt", int'(o_psc_cnt), 0);
    chk("wrap_tick", int'(o_tick), 1);
    for (int i = 0; i < 6; i++) cyc("div3", 1, 0, 0, 0, 0);
    // simultaneous write and transfer, then ug with en=0
    cyc("wr_uev", 1, 1, 5, 0, 1);
    chk("wr_uev_act", int'(o_psc_act), 2);
    chk("wr_uev_pre", int'(o_psc_pre), 5);
    chk("wr_uev_pend", int'(o_pend), 1);
    cyc("ug_en0", 0, 0, 0, 1, 0);
    chk("ug_en0_cnt", int'(o_psc_cnt), 0);
    chk("ug_en0_tick", int'(o_tick), 0);
    // all-ones PSC: ratio 2^W
    cyc("wrM", 0, 1, M, 0, 0);
    cyc("ugM", 1, 0, 0, 1, 0);
    ticks = 0;
    for (int i = 0; i < 2 * (M + 1); i++) begin
      cyc("divM", 1, 0, 0, 0, 0);
      ticks += int'(o_tick);
    end
    chk("divM_ticks", ticks, 2);
`ifdef TIM_PSC_PRELOAD_BYPASS_EN
    for (int i = 0; i < 5; i++) cyc("pre_byp", 1, 0, 0, 0, 0);
    psc_pe = 0;
    cyc("byp4", 1, 1, 4, 0, 0);
    chk("byp4_act", int'(o_psc_act), 4);
    chk("byp4_pend", int'(o_pend), 0);
    chk("byp4_cnt", int'(o_psc_cnt), 6);
    for (int i = 0; i < 6; i++) cyc("byp_run", 1, 0, 0, 0, 0);
    psc_pe = 1;
`endif
    // random traffic
    for (int i = 0; i < 600; i++) begin
`ifdef TIM_PSC_PRELOAD_BYPASS_EN
      psc_pe = ($urandom_range(0, 3) != 0);
`endif
      cyc("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
          (($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : $urandom_range(0, M)),
          $urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
